prog_updown_counter: RTL and testbench

PROG_UPDOWN_COUNTER -- requirements
Module: prog_updown_counter

---
 rtl/prog_updown_counter.sv | 95 +++++++++
 tb/tb_prog_updown_counter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/prog_updown_counter.sv
// Programmable bounded up/down counter with saturate-or-wrap limits, load clamping,
// a registered terminal-count pulse and sticky overflow/underflow flags.
module prog_updown_counter #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic             up_down,
    input  logic [WIDTH-1:0] d_in,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lo_limit,
    input  logic [WIDTH-1:0] hi_limit,
    input  logic             sat_mode,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf_flag,
    output logic             unf_flag,
    output logic             cfg_err
);

    logic             cfg_bad;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   lo_plus_step;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             ovf_set;
    logic             unf_set;

    // Inverted limits are checked live so a bad bound pair never moves the count.
    assign cfg_bad      = (lo_limit > hi_limit);
    assign sum          = {1'b0, count} + {1'b0, step};
    assign lo_plus_step = {1'b0, lo_limit} + {1'b0, step};

    always_comb begin
        load_val = d_in;
        if (d_in < lo_limit) begin
            load_val = lo_limit;
        end else if (d_in > hi_limit) begin
            load_val = hi_limit;
        end
    end

    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (enable && !cfg_bad) begin
            if (load) begin
                count_nxt = load_val;
            end else if (step != '0) begin
                if (up_down) begin
                    if (sum > {1'b0, hi_limit}) begin
                        ovf_set   = 1'b1;
                        tc_nxt    = 1'b1;
                        count_nxt = sat_mode ? hi_limit : lo_limit;
                    end else begin
                        count_nxt = sum[WIDTH-1:0];
                    end
                end else begin
                    if ({1'b0, count} >= lo_plus_step) begin
                        count_nxt = count - step;
                    end else begin
                        unf_set   = 1'b1;
                        tc_nxt    = 1'b1;
                        count_nxt = sat_mode ? lo_limit : hi_limit;
                    end
                end
            end
        end
    end

    // A flag-setting event in the same cycle as clr_flags leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= RST_VAL;
            tc       <= 1'b0;
            ovf_flag <= 1'b0;
            unf_flag <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            count    <= count_nxt;
            tc       <= tc_nxt;
            ovf_flag <= ovf_set | (ovf_flag & ~clr_flags);
            unf_flag <= unf_set | (unf_flag & ~clr_flags);
            cfg_err  <= cfg_bad;
        end
    end

endmodule

// File: tb/tb_prog_updown_counter.sv
// Directed bench for prog_updown_counter: a vector table applied one clock at a time,
// then a hand-written asynchronous-reset sequence.
module tb_prog_updown_counter;

    localparam int         W   = 8;
    localparam logic [7:0] RSV = 8'd3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable, load, up_down, sat_mode, clr_flags;
    logic [W-1:0] d_in, step, lo_limit, hi_limit;
    logic [W-1:0] count;
    logic         tc, ovf_flag, unf_flag, cfg_err;

    int tests = 0;
    int fails = 0;

    prog_updown_counter #(.WIDTH(W), .RST_VAL(RSV)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .up_down(up_down),
        .d_in(d_in), .step(step), .lo_limit(lo_limit), .hi_limit(hi_limit),
        .sat_mode(sat_mode), .clr_flags(clr_flags), .count(count), .tc(tc),
        .ovf_flag(ovf_flag), .unf_flag(unf_flag), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // ctl = {enable, load, up_down, sat_mode, clr_flags}; fl = {tc, ovf, unf, cfg_err}
    typedef struct {
        logic [4:0] ctl;
        logic [7:0] d;
        logic [7:0] st;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] c;
        logic [3:0] fl;
    } vec_t;

    vec_t vt[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] c, input logic [3:0] fl);
        chk({tag, ".count"}, {24'd0, count}, {24'd0, c});
        chk({tag, ".tc"},    {31'd0, tc},       {31'd0, fl[3]});
        chk({tag, ".ovf"},   {31'd0, ovf_flag}, {31'd0, fl[2]});
        chk({tag, ".unf"},   {31'd0, unf_flag}, {31'd0, fl[1]});
        chk({tag, ".cfg"},   {31'd0, cfg_err},  {31'd0, fl[0]});
    endtask

    task automatic drive(input logic [4:0] ctl, input logic [7:0] d, input logic [7:0] st,
                         input logic [7:0] lo, input logic [7:0] hi);
        {enable, load, up_down, sat_mode, clr_flags} = ctl;
        d_in = d; step = st; lo_limit = lo; hi_limit = hi;
    endtask

    initial begin
        vt[0]  = '{5'b00100, 8'd0,   8'd1, 8'd0,  8'd255, 8'd3,   4'b0000};
        vt[1]  = '{5'b11100, 8'd255, 8'd1, 8'd0,  8'd255, 8'd255, 4'b0000};
        vt[2]  = '{5'b10100, 8'd0,   8'd1, 8'd0,  8'd255, 8'd0,   4'b1100};
        vt[3]  = '{5'b00100, 8'd0,   8'd1, 8'd0,  8'd255, 8'd0,   4'b0100};
        vt[4]  = '{5'b00101, 8'd0,   8'd1, 8'd0,  8'd255, 8'd0,   4'b0000};
        vt[5]  = '{5'b11110, 8'd19,  8'd3, 8'd10, 8'd20,  8'd19,  4'b0000};
        vt[6]  = '{5'b10110, 8'd0,   8'd3, 8'd10, 8'd20,  8'd20,  4'b1100};
        vt[7]  = '{5'b10110, 8'd0,   8'd3, 8'd10, 8'd20,  8'd20,  4'b1100};
        vt[8]  = '{5'b10111, 8'd0,   8'd3, 8'd10, 8'd20,  8'd20,  4'b1100};
        vt[9]  = '{5'b00001, 8'd0,   8'd3, 8'd10, 8'd20,  8'd20,  4'b0000};
        vt[10] = '{5'b11000, 8'd12,  8'd4, 8'd10, 8'd20,  8'd12,  4'b0000};
        vt[11] = '{5'b10000, 8'd0,   8'd4, 8'd10, 8'd20,  8'd20,  4'b1010};
        vt[12] = '{5'b00001, 8'd0,   8'd4, 8'd10, 8'd20,  8'd20,  4'b0000};
        vt[13] = '{5'b11000, 8'd200, 8'd4, 8'd10, 8'd50,  8'd50,  4'b0000};
        vt[14] = '{5'b11000, 8'd2,   8'd4, 8'd10, 8'd50,  8'd10,  4'b0000};
        vt[15] = '{5'b10000, 8'd0,   8'd0, 8'd10, 8'd50,  8'd10,  4'b0000};
        vt[16] = '{5'b10100, 8'd0,   8'd7, 8'd10, 8'd50,  8'd17,  4'b0000};
        vt[17] = '{5'b10000, 8'd0,   8'd5, 8'd10, 8'd50,  8'd12,  4'b0000};
        vt[18] = '{5'b10110, 8'd0,   8'd1, 8'd12, 8'd12,  8'd12,  4'b1100};
        vt[19] = '{5'b10010, 8'd0,   8'd1, 8'd12, 8'd12,  8'd12,  4'b1110};
        vt[20] = '{5'b00001, 8'd0,   8'd1, 8'd30, 8'd20,  8'd12,  4'b0001};
        vt[21] = '{5'b10100, 8'd0,   8'd1, 8'd30, 8'd20,  8'd12,  4'b0001};
        vt[22] = '{5'b11100, 8'd25,  8'd1, 8'd30, 8'd20,  8'd12,  4'b0001};
        vt[23] = '{5'b00100, 8'd0,   8'd1, 8'd0,  8'd255, 8'd12,  4'b0000};
        vt[24] = '{5'b10100, 8'd0,   8'd1, 8'd0,  8'd10,  8'd0,   4'b1100};
        vt[25] = '{5'b00001, 8'd0,   8'd1, 8'd0,  8'd10,  8'd0,   4'b0000};

        rst_n = 1'b0;
        drive(5'b00100, 8'd0, 8'd1, 8'd0, 8'd255);
        repeat (2) @(posedge clk);
        #1 chk_all("reset", RSV, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive(vt[i].ctl, vt[i].d, vt[i].st, vt[i].lo, vt[i].hi);
            @(posedge clk);
            #1 chk_all($sformatf("vec%0d", i), vt[i].c, vt[i].fl);
        end

        // Asynchronous reset between edges while an overflow pulse is active.
        @(negedge clk);
        drive(5'b11110, 8'd19, 8'd3, 8'd10, 8'd20);
        @(negedge clk);
        drive(5'b10110, 8'd0, 8'd3, 8'd10, 8'd20);
        @(posedge clk);
        #1 chk_all("pre_rst", 8'd20, 4'b1100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", RSV, 4'b0000);
        @(posedge clk);
        #1 chk_all("rst_held", RSV, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'b10100, 8'd0, 8'd1, 8'd0, 8'd255);
        @(posedge clk);
        #1 chk_all("post_rst", RSV + 8'd1, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
